// File: rtl/ifetch_mem_resp.sv
// rtl/ifetch_mem_resp.sv - instruction-fetch responder on a byte-wide RAM port
//
// Purpose: accepts a fetch request (PC + byte count) from the instruction
// queue, reads the bytes one per granted cycle from the shared 8-bit RAM,
// assembles them little-endian and returns the word with a one-cycle ins_ok.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rdy        global ready; low freezes all registered state
//   clear      synchronous pipeline flush, highest priority
//   req        fetch request (level), sampled only while idle
//   req_addr   PC of the instruction to fetch
//   req_bytes  byte count 1..MAX_BYTES; 0 or larger is treated as MAX_BYTES
//   grant      RAM bus available to the fetch side this cycle
//   mem_din    RAM read data, valid one cycle after its address
//   mem_a      RAM byte address (0 when no read is issued)
//   mem_wr     RAM write enable, tied low
//   ins_ok     one-cycle completion pulse
//   ins_ans    assembled instruction, held after ins_ok
//   busy       high from acceptance until completion
//
// Build option: define IFETCH_IO_GUARD_EN to answer fetches into the IO
// window (req_addr[17:16] == 2'b11) with a NOP without touching the RAM.

module ifetch_mem_resp #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_bytes,
  input  logic              grant,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic              ins_ok,
  output logic [31:0]       ins_ans,
  output logic              busy
);

  localparam int                CNT_W = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
  localparam logic [3:0]        MAXB  = 4'(MAX_BYTES);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [CNT_W-1:0]   n_q, iss_q, cap_q;
  logic               pend_q;
  logic [31:0]        buf_q;

  logic [CNT_W-1:0]   req_n;
  logic               issue, capture, last;
  logic               accept, io_accept, io_hit;
  logic [31:0]        buf_cap;

  assign mem_wr = 1'b0;

  assign req_n = (req_bytes == 4'd0 || req_bytes > MAXB) ? CNT_W'(MAX_BYTES)
                                                          : CNT_W'(req_bytes);

`ifdef IFETCH_IO_GUARD_EN
  assign io_hit = (req_addr[17:16] == 2'b11);
`else
  assign io_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    capture   = 1'b0;
    last      = 1'b0;
    mem_a     = '0;
    buf_cap   = buf_q;
    accept    = (state_q == IDLE) && req && !clear && !io_hit;
    io_accept = (state_q == IDLE) && req && !clear && io_hit;

    if (state_q == FETCH) begin
      issue   = grant && (iss_q < n_q);
      // The byte returning now belongs to the read issued last cycle; it is
      // captured regardless of grant, since the bus was ours when issued.
      capture = pend_q;
      last    = pend_q && ((cap_q + ONE) == n_q);
    end

    if (issue) mem_a = base_q + ADDR_W'(iss_q);
    if (capture) buf_cap[{cap_q, 3'b000} +: 8] = mem_din;

    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (clear || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      n_q     <= '0;
      iss_q   <= '0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      ins_ok  <= 1'b0;
      ins_ans <= '0;
      busy    <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      ins_ok  <= 1'b0;
      if (clear) begin
        // Dropping pend discards any byte still in flight from the RAM.
        pend_q <= 1'b0;
        iss_q  <= '0;
        cap_q  <= '0;
        busy   <= 1'b0;
      end else if (state_q == IDLE) begin
        pend_q <= 1'b0;
        if (accept) begin
          base_q <= req_addr;
          n_q    <= req_n;
          iss_q  <= '0;
          cap_q  <= '0;
          buf_q  <= '0;
          busy   <= 1'b1;
        end else if (io_accept) begin
          ins_ok  <= 1'b1;
          ins_ans <= 32'h0000_0013;
        end
      end else begin
        pend_q <= issue;
        if (issue) iss_q <= iss_q + ONE;
        if (capture) begin
          buf_q <= buf_cap;
          cap_q <= cap_q + ONE;
        end
        if (last) begin
          ins_ok  <= 1'b1;
          ins_ans <= buf_cap;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_mem_resp.sv
// tb/tb_ifetch_mem_resp.sv - self-checking bench for ifetch_mem_resp

module tb_ifetch_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        req;
  logic [31:0] req_addr;
  logic [3:0]  req_bytes;
  logic        grant;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        ins_ok;
  logic [31:0] ins_ans;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram_ovr [logic [31:0]];

  always #5 clk = ~clk;

  ifetch_mem_resp #(.ADDR_W(32), .MAX_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .req       (req),
    .req_addr  (req_addr),
    .req_bytes (req_bytes),
    .grant     (grant),
    .mem_din   (mem_din),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .ins_ok    (ins_ok),
    .ins_ans   (ins_ans),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram_ovr.exists(a)) return ram_ovr[a];
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  // One clock; the RAM returns the byte for the address shown in the cycle
  // just ended, and like the rest of the system it holds while rdy is low.
  task automatic step();
    logic [31:0] a_prev;
    logic        r_prev;
    a_prev = mem_a;
    r_prev = rdy;
    @(posedge clk);
    #1;
    if (r_prev) mem_din = ram_byte(a_prev);
  endtask

  // Presents one request and follows it to completion. The reference keeps
  // only the list of addresses still to be read (addr+k for k<n) and the
  // rule that the last byte lands one active edge after its read, after
  // which ins_ok shows the little-endian word.
  task automatic run_fetch(input logic [31:0] addr, input logic [3:0] bytes,
                           input int gpct, input int glow_s, input int glow_l,
                           input int rlow_s, input int rlow_l, input bit rnd_rdy,
                           output int lat);
    int          n;
    int          k;
    logic [31:0] exp_word;
    logic [31:0] exp_a;
    bit          exp_ok;
    bit          cap_due;
    bit          done;
    n = (bytes == 4'd0 || bytes > 4'd4) ? 4 : int'(bytes);
    exp_word = 32'h0;
    for (int i = 0; i < n; i++)
      exp_word = exp_word | (32'(ram_byte(addr + 32'(i))) << (8 * i));
    req       = 1'b1;
    req_addr  = addr;
    req_bytes = bytes;
    clear     = 1'b0;
    rdy       = 1'b1;
    grant     = ($urandom_range(99) < gpct);
    #1;
    check_eq("idle_mem_a", mem_a, 32'h0);
    check_eq("mem_wr", mem_wr, 1'b0);
    step();
    k = 0; exp_ok = 0; cap_due = 0; done = 0; lat = -1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (glow_s >= 0 && cyc >= glow_s && cyc < glow_s + glow_l) grant = 1'b0;
      else grant = ($urandom_range(99) < gpct);
      if (rlow_s >= 0 && cyc >= rlow_s && cyc < rlow_s + rlow_l) rdy = 1'b0;
      else if (rnd_rdy && k < n && $urandom_range(9) == 0) rdy = 1'b0;
      else rdy = 1'b1;
      #1;
      exp_a = (k < n && grant) ? addr + 32'(k) : 32'h0;
      check_eq("mem_a", mem_a, exp_a);
      check_eq("ins_ok", ins_ok, exp_ok);
      check_eq("busy", busy, !exp_ok);
      if (exp_ok) begin
        check_eq("ins_ans", ins_ans, exp_word);
        req  = 1'b0;
        done = 1;
        lat  = cyc;
      end else begin
        if (rdy) begin
          exp_ok  = cap_due;
          cap_due = 0;
          if (k < n && grant) begin
            k++;
            if (k == n) cap_due = 1;
          end
        end
        step();
      end
    end
    if (!done) check_eq("timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int          lat;
    logic [31:0] a;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; req = 1'b0;
    req_addr = 32'h0; req_bytes = 4'd0; grant = 1'b0; mem_din = 8'h0;
    ram_ovr[32'h1000] = 8'h93;
    ram_ovr[32'h1001] = 8'h00;
    ram_ovr[32'h1002] = 8'h50;
    ram_ovr[32'h1003] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_a", mem_a, 32'h0);
    check_eq("rst_mem_wr", mem_wr, 1'b0);
    check_eq("rst_ins_ok", ins_ok, 1'b0);
    check_eq("rst_ins_ans", ins_ans, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b1;
    step();

    run_fetch(32'h1000, 4'd4, 100, -1, 0, -1, 0, 0, lat);
    check_eq("lat_basic", lat, 5);
    check_eq("word_basic", ins_ans, 32'h0050_0093);

    run_fetch(32'h1000, 4'd4, 100, 2, 2, -1, 0, 0, lat);
    check_eq("lat_grant_gap", lat, 7);
    check_eq("word_grant_gap", ins_ans, 32'h0050_0093);

    run_fetch(32'h1000, 4'd4, 100, -1, 0, 1, 3, 0, lat);
    check_eq("lat_rdy_freeze", lat, 8);
    check_eq("word_rdy_freeze", ins_ans, 32'h0050_0093);

    run_fetch(32'h1000, 4'd2, 100, -1, 0, -1, 0, 0, lat);
    check_eq("lat_two_bytes", lat, 3);
    check_eq("word_two_bytes", ins_ans, 32'h0000_0093);

`ifndef IFETCH_IO_GUARD_EN
    run_fetch(32'hFFFF_FFFE, 4'd0, 100, -1, 0, -1, 0, 0, lat);
    check_eq("lat_wrap", lat, 5);
    run_fetch(32'h0003_0004, 4'd4, 100, -1, 0, -1, 0, 0, lat);
    check_eq("lat_io_plain", lat, 5);
`endif

    // Flush three cycles into a fetch with req still high.
    req = 1'b1; req_addr = 32'h2000; req_bytes = 4'd4; grant = 1'b1; rdy = 1'b1;
    step();
    step();
    step();
    clear = 1'b1;
    #1;
    check_eq("clr_ins_ok_before", ins_ok, 1'b0);
    step();
    clear = 1'b0;
    #1;
    check_eq("clr_busy", busy, 1'b0);
    check_eq("clr_ins_ok", ins_ok, 1'b0);
    check_eq("clr_not_accepted", mem_a, 32'h0);
    run_fetch(32'h1000, 4'd4, 100, -1, 0, -1, 0, 0, lat);
    check_eq("lat_after_clear", lat, 5);

`ifdef IFETCH_IO_GUARD_EN
    req = 1'b1; req_addr = 32'h0003_0004; req_bytes = 4'd4; grant = 1'b1;
    #1;
    check_eq("io_mem_a_req", mem_a, 32'h0);
    step();
    req = 1'b0;
    #1;
    check_eq("io_ins_ok", ins_ok, 1'b1);
    check_eq("io_ins_ans", ins_ans, 32'h0000_0013);
    check_eq("io_busy", busy, 1'b0);
    check_eq("io_mem_a", mem_a, 32'h0);
    step();
    #1;
    check_eq("io_ins_ok_drop", ins_ok, 1'b0);
    check_eq("io_mem_a_after", mem_a, 32'h0);
`endif

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      if (t % 5 == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(3));
`ifdef IFETCH_IO_GUARD_EN
      a[17] = 1'b0;
`endif
      run_fetch(a, 4'($urandom_range(15)), $urandom_range(100, 40), -1, 0, -1, 0, 1, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_mem_resp.md
# ifetch_mem_resp

Instruction-fetch responder on the memory-controller side of the fetch handshake. The instruction queue raises a fetch request carrying a PC and a byte count. This block drives the byte-wide RAM port, assembles the little-endian instruction word, and returns it with a one-cycle `ins_ok` pulse. It sits between the instruction queue and the shared 8-bit RAM, and yields the bus whenever the data-side port holds it.

## Interface
Parameters:
- `ADDR_W`, 32: width of the fetch address and `mem_a`.
- `MAX_BYTES`, 4: maximum bytes per fetch (one RV32 instruction).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global ready; low freezes all state.
- `clear`  in  1  pipeline flush (branch mispredict); synchronous.
- `req`  in  1  fetch request; level, sampled only in IDLE.
- `req_addr`  in  ADDR_W  PC of the instruction to fetch.
- `req_bytes`  in  4  byte count; 1..4 valid; 0 or >4 is treated as 4.
- `grant`  in  1  bus available to fetch this cycle; 0 while the data port owns the RAM.
- `mem_din`  in  8  RAM read data, valid one cycle after its address.
- `mem_a`  out  ADDR_W  RAM byte address.
- `mem_wr`  out  1  RAM write enable; constant 0 (read-only port).
- `ins_ok`  out  1  one-cycle completion pulse.
- `ins_ans`  out  32  assembled instruction; valid while `ins_ok`=1, then held.
- `busy`  out  1  high from request acceptance until `ins_ok`.

## Operation
- State machine: IDLE, FETCH.
  - IDLE -> FETCH on a rising edge with `req`=1 and `clear`=0.
  - FETCH -> IDLE when the last byte is captured, or on `clear`.
- On acceptance, latch:
  - `base` <= `req_addr`
  - `n` <= normalised `req_bytes`
  - issue counter `iss` <= 0, capture counter `cap` <= 0
  - word buffer <= 0
- Issue in FETCH:
  - When `grant`=1 and `iss`<`n`: `mem_a` = `base`+`iss` (modulo 2^ADDR_W), `iss` increments, and `pend` <= 1.
  - Otherwise `pend` <= 0 and `mem_a` = 0.
- Capture: when `pend`=1, write `mem_din` into buffer bits [8*`cap`+7 : 8*`cap`], and `cap` increments.
  - A byte in flight is captured even if `grant` drops in the capture cycle.
- Completion: at the edge where `cap` becomes `n`:
  - `ins_ans` <= buffer including this byte; bytes >= `n` stay 0.
  - `ins_ok` <= 1 for exactly one cycle; state -> IDLE; `busy` falls.
- `req` while in FETCH is ignored; the requester holds it until it sees `ins_ok`.
- `clear` has priority over everything:
  - State -> IDLE, `pend`/`iss`/`cap` cleared, no `ins_ok` issued.
  - A `req` on the same edge is not accepted.
  - A RAM byte returning after `clear` is discarded.
- `rdy`=0: no state, counter or output register changes; `mem_a` keeps its combinational value from frozen state.

## Timing
- Reset values: state IDLE, `mem_a`=0, `mem_wr`=0, `ins_ok`=0, `ins_ans`=0, `busy`=0, `pend`=0.
- Full 4-byte fetch, `grant` held high, request accepted at edge E0:
  - Addresses issued in the cycles after E0, E1, E2, E3.
  - Bytes captured at E2, E3, E4, E5.
  - `ins_ok` high in the cycle after E5.
  - Latency 5 cycles from acceptance.
- Each cycle with `grant`=0 during issue adds one cycle of latency.
- A new `req` may be accepted on the edge that ends the `ins_ok` cycle (back-to-back).
- `busy` is registered; it rises the cycle after acceptance.

## Configuration
- `IFETCH_IO_GUARD_EN` defined:
  - A request with `req_addr[17:16]`==2'b11 (IO window 0x30000) completes without any RAM access.
  - `ins_ok`=1 and `ins_ans`=32'h00000013 (NOP) in the cycle after acceptance.
  - `mem_a` stays 0 throughout.
- Not defined: IO-window addresses are fetched from RAM like any other address.

## Test plan
- Reset, then `req`, `req_addr`=0x1000, `req_bytes`=4, `grant`=1, RAM bytes 0x93,0x00,0x50,0x00 -> `mem_a` 0x1000..0x1003 on consecutive cycles; `ins_ok` 5 cycles after acceptance with `ins_ans`=0x00500093.
- Same fetch with `grant`=0 for 2 cycles after the second address -> the second byte is still captured; `ins_ok` at 7 cycles; `ins_ans` unchanged.
- `clear` asserted 3 cycles into a fetch with `req` also high -> no `ins_ok`, `busy`=0 next cycle, `req` not accepted that edge; accepted on the next edge.
- `req_bytes`=0 and `req_addr`=0xFFFFFFFE -> 4 bytes read at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap).
- `rdy`=0 for 3 cycles mid-fetch -> counters and `ins_ans` frozen; completes 3 cycles late with the correct word.
- With `IFETCH_IO_GUARD_EN`, `req_addr`=0x30004 -> `ins_ok` next cycle, `ins_ans`=0x00000013, no RAM address issued.
